ifetch_prefetch_queue: RTL and testbench
========================================

Name: ifetch_prefetch_queue

Overview:
- Instruction fetch front end between byte-wide program memory and the execute stage (lsu/alu).
- Reads 16-bit instructions as two byte reads, low byte at PC and high byte at PC+1, and assembles them.
- Buffers assembled instructions in a small FIFO with the fetch PC attached.
- Execute consumes via valid/ready; branch redirects flush the queue and restart fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
RESET_PC, 16'h0800, fetch address loaded on reset.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
mem_req  output  1  bus request to arbiter (shared with lsu).
mem_grant  input  1  arbiter grant; arbiter holds it while mem_req=1.
mem_addr  output  16  byte address; 16'h0000 when mem_cs=0.
mem_cs  output  1  memory chip select, address phase.
mem_we  output  1  write enable; constant 0.
mem_rdata  input  8  read data; valid the cycle after the address phase.
redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc.
redirect_pc  input  16  new fetch address.
instr_valid  output  1  FIFO head valid.
instr_ready  input  1  execute accepts the head.
instr_data  output  16  head instruction {hi_byte, lo_byte}.
instr_pc  output  16  address of the head's low byte.

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, FIFO empty, state=ADDR_LO. Outputs: mem_req=0, mem_cs=0, mem_addr=0, mem_we=0, instr_valid=0, instr_data=0, instr_pc=0.
- FSM states: ADDR_LO -> DATA_LO -> ADDR_HI -> DATA_HI -> ADDR_LO.
- ADDR_LO:
  - Start condition: entries < DEPTH, after counting any pop in the same cycle.
  - If the start condition holds: mem_req=1. If mem_grant=1 also, mem_cs=1, mem_addr=fetch_pc, advance; otherwise hold.
  - If the start condition fails: mem_req=0, hold.
- DATA_LO: mem_req=1, mem_cs=0; capture mem_rdata into lo_byte.
- ADDR_HI: mem_req=1; if mem_grant=1, mem_cs=1, mem_addr=fetch_pc+1 (16-bit wrap), advance; otherwise hold with mem_cs=0.
- DATA_HI:
  - Capture mem_rdata as hi_byte.
  - Push {hi,lo} and fetch_pc to the FIFO.
  - fetch_pc += 2 (mod 2^16).
  - mem_req drops next cycle unless a new fetch starts.
- Latency: first instr_valid 4 cycles after the first ADDR_LO with grant. Throughput: 1 instruction per 4 cycles.
- FIFO:
  - Pop when instr_valid & instr_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Push into a full FIFO never occurs, because the fetch is gated at ADDR_LO.
  - Outputs are registered head; instr_data and instr_pc hold stable while instr_valid=1 and instr_ready=0.
- Redirect (priority over everything except rst):
  - Next cycle: FIFO empty, instr_valid=0, state=ADDR_LO, fetch_pc=redirect_pc.
  - An in-flight byte fetch is abandoned and its data dropped.
  - A pop in the same cycle is discarded.
- Wrap: fetch_pc=16'hFFFF reads lo at FFFF, hi at 0000; next fetch_pc=16'h0001.
- Odd PCs are legal (byte-addressed), no alignment enforcement.
- rst mid-fetch: abandoned immediately, same as reset.

Optional Feature:
- Macro: IFETCH_STALL_CNT_EN.
- When defined: adds output fetch_stall_cnt [15:0]. It increments each cycle with instr_ready=1 and instr_valid=0, saturates at 16'hFFFF, is cleared by rst, and is not cleared by redirect.
- When undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Reset release, mem[0800]=34, mem[0801]=12, grant=1, ready=1 -> mem_addr 0800 in cycle 0, 0801 in cycle 2; instr_valid=1 in cycle 4 with instr_data=16'h1234, instr_pc=16'h0800.
- ready=0, DEPTH=4, grant=1 -> four entries (pcs 0800,0802,0804,0806) after 16 cycles; mem_cs stays 0 thereafter; pop one -> fetch of 0808 starts next cycle.
- Redirect to 16'h1000 in DATA_LO of the 0802 fetch with one entry queued -> next cycle instr_valid=0; next mem_cs=1 at addr 1000; no instruction with pc 0802 ever appears.
- grant=0 for 3 cycles during ADDR_HI -> mem_req=1, mem_cs=0 held; after grant returns, correct hi byte; instr_data matches memory.
- Redirect to 16'hFFFF, mem[FFFF]=AB, mem[0000]=CD -> instr_data=16'hCDAB, instr_pc=16'hFFFF; next fetch address 0001.
- IFETCH_STALL_CNT_EN defined, ready=1 from reset -> fetch_stall_cnt=4 when the first instr_valid rises; unchanged while valid stays high.

Source files
------------

// File: rtl/ifetch_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: byte memory port,
// branch redirect and the instruction stream handed to execute.
// master = fetch unit, slave = memory/arbiter/execute environment.
interface ifetch_prefetch_queue_if;
  logic        mem_req;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;

  modport master (
    output mem_req, mem_addr, mem_cs, mem_we, instr_valid, instr_data, instr_pc,
    input  mem_grant, mem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, mem_cs, mem_we, instr_valid, instr_data, instr_pc,
    output mem_grant, mem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit instructions as two byte reads
// (lo at PC, hi at PC+1), queues {instr, pc} in a DEPTH-entry FIFO, and
// flushes/restarts on a branch redirect.
// Optional: define IFETCH_STALL_CNT_EN to add the fetch_stall_cnt output,
// counting cycles where execute is ready but no instruction is available.
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0800
) (
  input  logic clk,
  input  logic rst,
  ifetch_prefetch_queue_if.master bus
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0] fetch_stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {ADDR_LO, DATA_LO, ADDR_HI, DATA_HI} state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [7:0]    lo_byte;
  logic [15:0]   q_data [DEPTH];
  logic [15:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          pop, push, start;

  assign pop   = bus.instr_valid & bus.instr_ready;
  assign push  = (state == DATA_HI);
  // A pop in this cycle frees a slot, so it lets a new fetch start at once.
  assign start = (int'(count) - int'(pop)) < DEPTH;

  // Head of the FIFO; zeroed when empty so nothing stale leaks out.
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = bus.instr_valid ? q_data[rd_ptr] : 16'h0000;
  assign bus.instr_pc    = bus.instr_valid ? q_pc[rd_ptr]   : 16'h0000;
  assign bus.mem_we      = 1'b0;

  // Memory port: address phase depends on the grant seen this cycle.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_cs   = 1'b0;
    bus.mem_addr = 16'h0000;
    if (!rst) begin
      case (state)
        ADDR_LO: if (start) begin
          bus.mem_req = 1'b1;
          if (bus.mem_grant) begin
            bus.mem_cs   = 1'b1;
            bus.mem_addr = fetch_pc;
          end
        end
        DATA_LO: bus.mem_req = 1'b1;
        ADDR_HI: begin
          bus.mem_req = 1'b1;
          if (bus.mem_grant) begin
            bus.mem_cs   = 1'b1;
            bus.mem_addr = fetch_pc + 16'd1;
          end
        end
        DATA_HI: bus.mem_req = 1'b1;
        default: ;
      endcase
    end
  end

  // Fetch sequencer: two byte reads per instruction; redirect abandons any
  // in-flight read and restarts at the new PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ADDR_LO;
      fetch_pc <= RESET_PC;
      lo_byte  <= 8'h00;
    end else if (bus.redirect_valid) begin
      state    <= ADDR_LO;
      fetch_pc <= bus.redirect_pc;
    end else begin
      case (state)
        ADDR_LO: if (start && bus.mem_grant) state <= DATA_LO;
        DATA_LO: begin
          lo_byte <= bus.mem_rdata;
          state   <= ADDR_HI;
        end
        ADDR_HI: if (bus.mem_grant) state <= DATA_HI;
        DATA_HI: begin
          fetch_pc <= fetch_pc + 16'd2;
          state    <= ADDR_LO;
        end
        default: state <= ADDR_LO;
      endcase
    end
  end

  // Instruction FIFO; redirect empties it and discards a same-cycle pop/push.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= {bus.mem_rdata, lo_byte};
        q_pc[wr_ptr]   <= fetch_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  // Saturating count of cycles execute waited on an empty queue.
  always_ff @(posedge clk) begin
    if (rst) fetch_stall_cnt <= 16'h0000;
    else if (bus.instr_ready && !bus.instr_valid && fetch_stall_cnt != 16'hFFFF)
      fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for ifetch_prefetch_queue with a byte memory model
// (read data returned the cycle after the address phase).
module tb_ifetch_prefetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] mem [0:65535];

  ifetch_prefetch_queue_if bus ();

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] fetch_stall_cnt;
`endif

  ifetch_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0800)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_cs) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = 16'(a);
      mem[a] = av[7:0] ^ av[15:8];
    end
    mem[16'h0800] = 8'h34;
    mem[16'h0801] = 8'h12;
    mem[16'hFFFF] = 8'hAB;
    mem[16'h0000] = 8'hCD;
    bus.mem_grant      = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.mem_rdata      = 8'h00;

    // Reset state, then first fetch with grant and ready held high.
    rst = 1'b1;
    tick(); tick();
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_cs", bus.mem_cs, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_data", bus.instr_data, 16'h0000);
    chk("rst_pc", bus.instr_pc, 16'h0000);
    rst = 1'b0;
    #1;
    chk("c0_cs", bus.mem_cs, 1'b1);
    chk("c0_addr", bus.mem_addr, 16'h0800);
    tick(); #1;
    chk("c1_req", bus.mem_req, 1'b1);
    chk("c1_cs", bus.mem_cs, 1'b0);
    tick(); #1;
    chk("c2_addr", bus.mem_addr, 16'h0801);
    tick(); #1;
    chk("c3_valid", bus.instr_valid, 1'b0);
    tick(); #1;
    chk("c4_valid", bus.instr_valid, 1'b1);
    chk("c4_data", bus.instr_data, 16'h1234);
    chk("c4_pc", bus.instr_pc, 16'h0800);
    chk("c4_next_addr", bus.mem_addr, 16'h0802);
`ifdef IFETCH_STALL_CNT_EN
    chk("stall_at_valid", fetch_stall_cnt, 16'd4);
    tick(); #1;
    chk("stall_after_pop", fetch_stall_cnt, 16'd4);
`endif

    // Fill to DEPTH with execute stalled; fetch gated until a pop.
    bus.instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    #1;
    chk("full_head_pc", bus.instr_pc, 16'h0800);
    chk("full_req", bus.mem_req, 1'b0);
    chk("full_cs", bus.mem_cs, 1'b0);
    tick(); tick(); tick(); #1;
    chk("full_cs_hold", bus.mem_cs, 1'b0);
    bus.instr_ready = 1'b1;
    #1;
    chk("pop_fetch_cs", bus.mem_cs, 1'b1);
    chk("pop_fetch_addr", bus.mem_addr, 16'h0808);
    tick();
    bus.instr_ready = 1'b0;
    #1;
    chk("pop_next_pc", bus.instr_pc, 16'h0802);
    chk("pop_next_data", bus.instr_data, 16'h0B0A);

    // Redirect during DATA_LO of the 0802 fetch with one entry queued.
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("redir_pre_valid", bus.instr_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h1000;
    tick();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    #1;
    chk("redir_valid", bus.instr_valid, 1'b0);
    chk("redir_cs", bus.mem_cs, 1'b1);
    chk("redir_addr", bus.mem_addr, 16'h1000);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("redir_pc0", bus.instr_pc, 16'h1000);
    chk("redir_data0", bus.instr_data, 16'h1110);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("redir_pc1", bus.instr_pc, 16'h1002);
    chk("redir_data1", bus.instr_data, 16'h1312);

    // Grant withheld for three cycles in ADDR_HI.
    bus.instr_ready = 1'b0;
    do_reset();
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      bus.mem_grant = 1'b0;
      #1;
      chk("nogrant_req", bus.mem_req, 1'b1);
      chk("nogrant_cs", bus.mem_cs, 1'b0);
      tick();
    end
    bus.mem_grant = 1'b1;
    #1;
    chk("regrant_addr", bus.mem_addr, 16'h0801);
    tick(); tick(); #1;
    chk("regrant_valid", bus.instr_valid, 1'b1);
    chk("regrant_data", bus.instr_data, 16'h1234);

    // Address wrap at FFFF.
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFF;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_lo_addr", bus.mem_addr, 16'hFFFF);
    tick(); tick(); #1;
    chk("wrap_hi_addr", bus.mem_addr, 16'h0000);
    tick(); tick(); #1;
    chk("wrap_data", bus.instr_data, 16'hCDAB);
    chk("wrap_pc", bus.instr_pc, 16'hFFFF);
    chk("wrap_next_addr", bus.mem_addr, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
